// File: rtl/sevenseg_monitor.sv
// Recovers the hex value shown on a multiplexed 4-digit seven-segment display.
// Samples {an, seg}, debounces per digit, and publishes a full frame once all four digits are seen.
module sevenseg_monitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic [3:0]  digit_err,
    output logic        fsm_state
);

    typedef enum logic {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [3:0]  samp_an;
    logic [6:0]  samp_seg;
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic [7:0]  stable_cnt;
    logic [7:0]  cnt_next;
    logic [15:0] slots;
    logic [3:0]  captured;
    logic [3:0]  pend_err;
    state_t      state;
    state_t      state_next;

    logic        same;
    logic [3:0]  sel;
    logic        one_low;
    logic        capture;
    logic [3:0]  dec_nib;
    logic        dec_bad;

    always_comb begin
        dec_bad = 1'b0;
        dec_nib = 4'h0;
        case (samp_seg)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_bad = 1'b1;
        endcase
    end

    // A capture fires only on the edge where the counter first reaches STABLE,
    // so a digit held for a long time is taken once.
    always_comb begin
        same     = ({samp_an, samp_seg} == {prev_an, prev_seg});
        cnt_next = 8'd1;
        if (same) begin
            cnt_next = (stable_cnt == STABLE) ? stable_cnt : stable_cnt + 8'd1;
        end
        sel     = ~samp_an;
        one_low = (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
        capture = one_low && (cnt_next == STABLE) && (stable_cnt != STABLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (captured == 4'hF) state_next = PUBLISH;
            PUBLISH: state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_an    <= 4'hF;
            samp_seg   <= 7'h00;
            prev_an    <= 4'hF;
            prev_seg   <= 7'h00;
            stable_cnt <= 8'd0;
            state      <= COLLECT;
        end else begin
            samp_an    <= an;
            samp_seg   <= seg;
            prev_an    <= samp_an;
            prev_seg   <= samp_seg;
            stable_cnt <= cnt_next;
            state      <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= 16'h0000;
        end else if (capture) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) slots[4*k +: 4] <= dec_nib;
            end
        end
    end

    // Publishing clears the frame bookkeeping; a capture in the same cycle seeds the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured <= 4'h0;
            pend_err <= 4'h0;
        end else if (state == PUBLISH) begin
            captured <= capture ? sel : 4'h0;
            pend_err <= (capture && dec_bad) ? sel : 4'h0;
        end else if (capture) begin
            captured <= captured | sel;
            pend_err <= (pend_err & ~sel) | (dec_bad ? sel : 4'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= 16'h0000;
            valid     <= 1'b0;
            err       <= 1'b0;
            digit_err <= 4'h0;
        end else begin
            valid <= (state == PUBLISH);
            if (state == PUBLISH) begin
                value     <= slots;
                digit_err <= pend_err;
                err       <= |pend_err;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_monitor.sv
// Bench for sevenseg_monitor: a run-length model of the sampled display stream predicts
// every frame, and directed scenarios pin the model with literal expectations.
module tb_sevenseg_monitor;

    localparam int S = 4;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [3:0]  digit_err;
    logic        fsm_state;

    sevenseg_monitor #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .an        (an),
        .value     (value),
        .valid     (valid),
        .err       (err),
        .digit_err (digit_err),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int vcount  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          cyc = 0;
    logic [10:0] last;
    int          run;
    logic [3:0]  m_mask;
    logic [3:0]  m_err;
    logic [3:0]  m_slot [4];
    int          exp_t [$];
    logic [15:0] exp_v [$];
    logic [3:0]  exp_d [$];

    task automatic model_capture(input logic [3:0] a, input logic [6:0] s);
        int  k;
        logic found;
        k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) k = i;
        found     = 1'b0;
        m_slot[k] = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == s) begin
                m_slot[k] = 4'(i);
                found     = 1'b1;
            end
        end
        m_err[k]  = !found;
        m_mask[k] = 1'b1;
        if (m_mask == 4'hF) begin
            exp_t.push_back(cyc + 3);
            exp_v.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            exp_d.push_back(m_err);
            m_mask = 4'h0;
            m_err  = 4'h0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            last   = {4'hF, 7'h00};
            run    = 1;
            m_mask = 4'h0;
            m_err  = 4'h0;
            for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
            exp_t.delete();
            exp_v.delete();
            exp_d.delete();
        end else if ({an, seg} == last) begin
            if (run < S) begin
                run++;
                if (run == S && $countones(~an) == 1) model_capture(an, seg);
            end
        end else begin
            run  = 1;
            last = {an, seg};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] h_value = 16'h0;
    logic [3:0]  h_derr  = 4'h0;

    always @(negedge clk) begin
        logic ev;
        if (rst) begin
            h_value = 16'h0;
            h_derr  = 4'h0;
            chk("rst_valid", {31'b0, valid}, 32'd0);
            chk("rst_value", {16'b0, value}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_digit_err", {28'b0, digit_err}, 32'd0);
        end else begin
            ev = (exp_t.size() > 0) && (exp_t[0] == cyc);
            if (ev) begin
                void'(exp_t.pop_front());
                h_value = exp_v.pop_front();
                h_derr  = exp_d.pop_front();
            end
            if (valid === 1'b1) vcount++;
            chk("cyc_valid", {31'b0, valid}, {31'b0, ev});
            chk("cyc_value", {16'b0, value}, {16'b0, h_value});
            chk("cyc_err", {31'b0, err}, {31'b0, |h_derr});
            chk("cyc_digit_err", {28'b0, digit_err}, {28'b0, h_derr});
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        @(posedge clk);
        #2;
        an  = a;
        seg = s;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic dig(input int k, input logic [6:0] s, input int n);
        drive(~(4'b0001 << k), s, n);
    endtask

    task automatic blank(input int n);
        drive(4'hF, 7'h00, n);
    endtask

    task automatic lit(input string name, input int base, input int dv,
                       input logic [15:0] v, input logic e, input logic [3:0] d);
        @(negedge clk);
        #1;
        chk({name, "_count"}, 32'(vcount - base), 32'(dv));
        chk({name, "_value"}, {16'b0, value}, {16'b0, v});
        chk({name, "_err"}, {31'b0, err}, {31'b0, e});
        chk({name, "_digit_err"}, {28'b0, digit_err}, {28'b0, d});
    endtask

    initial begin
        int base;
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h00;
        repeat (3) @(posedge clk);
        lit("reset", vcount, 0, 16'h0000, 1'b0, 4'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // clean frame 3,2,1,0
        base = vcount;
        dig(3, 7'h4F, 6); dig(2, 7'h5B, 6); dig(1, 7'h06, 6); dig(0, 7'h3F, 6);
        blank(6);
        lit("clean", base, 1, 16'h3210, 1'b0, 4'h0);

        // undecodable digit 2
        base = vcount;
        dig(3, 7'h71, 6); dig(2, 7'h00, 6); dig(1, 7'h71, 6); dig(0, 7'h71, 6);
        blank(6);
        lit("bad_digit", base, 1, 16'hF0FF, 1'b1, 4'b0100);

        // glitch, then long hold, then proof of a single capture
        base = vcount;
        dig(3, 7'h06, 6); dig(2, 7'h06, 6); dig(1, 7'h06, 6);
        dig(0, 7'h66, 3);
        blank(6);
        lit("glitch", base, 0, 16'hF0FF, 1'b1, 4'b0100);
        dig(0, 7'h66, 24);
        blank(4);
        lit("long_hold", base, 1, 16'h1114, 1'b0, 4'h0);
        dig(3, 7'h3F, 6); dig(2, 7'h3F, 6); dig(1, 7'h3F, 6);
        blank(6);
        lit("single_capture", base, 1, 16'h1114, 1'b0, 4'h0);
        dig(0, 7'h7F, 6);
        blank(6);
        lit("glitch_done", base, 2, 16'h0008, 1'b0, 4'h0);

        // blanking and multi-select are ignored
        base = vcount;
        dig(3, 7'h6D, 6); dig(2, 7'h7D, 6);
        drive(4'hF, 7'h7F, 10);
        drive(4'b0011, 7'h06, 10);
        lit("ignored", base, 0, 16'h0008, 1'b0, 4'h0);
        dig(1, 7'h07, 6); dig(0, 7'h77, 6);
        blank(6);
        lit("partial_kept", base, 1, 16'h567A, 1'b0, 4'h0);

        // reset mid-frame
        dig(3, 7'h39, 6); dig(2, 7'h5E, 6); dig(1, 7'h79, 6);
        @(posedge clk);
        #2 rst = 1'b1;
        lit("in_reset", vcount, 0, 16'h0000, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        base = vcount;
        dig(0, 7'h79, 6);
        blank(8);
        lit("after_reset", base, 0, 16'h0000, 1'b0, 4'h0);

        // recapture overwrites digit 0
        base = vcount;
        dig(0, 7'h06, 6); dig(0, 7'h66, 6);
        dig(3, 7'h3F, 6); dig(2, 7'h3F, 6); dig(1, 7'h3F, 6);
        blank(6);
        lit("recapture", base, 1, 16'h0004, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
